ascon_round_ctrl: RTL and testbench

Sequencer for the Ascon permutation datapath. It sits between the SPI subnode's operation_mode/operation_ready outputs and the 320-bit state register/round-function logic. On each newly requested operation it issues single-cycle state-update strobes and then a counted burst of round enables with round-constant indices. It reports busy/done/error and blocks host state writes while running.

---
 rtl/ascon_pkg.sv | 70 +++++++
 rtl/ascon_round_ctrl_if.sv | 31 +++
 rtl/ascon_round_counter.sv | 79 +++++++
 rtl/ascon_round_ctrl.sv | 129 ++++++++++++
 tb/tb_ascon_round_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon control definitions: operation modes, sequencer states and strobe helpers.
// Also used by the SPI subnode for its operation_mode encoding.
package ascon_pkg;

    localparam int ASCON_MAX_ROUNDS = 12;

    typedef enum logic [2:0] {
        MODE_NONE     = 3'b000,
        MODE_INIT     = 3'b001,
        MODE_AD       = 3'b010,
        MODE_AD_LAST  = 3'b011,
        MODE_ENC      = 3'b100,
        MODE_ENC_LAST = 3'b101,
        MODE_FINAL    = 3'b110,
        MODE_RSVD     = 3'b111
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_ROUNDS = 3'd2,
        ST_POST   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic init_load;
        logic data_xor;
        logic key_xor_init;
        logic dsep_xor;
        logic key_xor_final;
        logic tag_xor;
    } strobe_t;

    function automatic logic mode_legal(input logic [2:0] m);
        return (m != 3'b000) && (m != 3'b111);
    endfunction

    function automatic strobe_t pre_strobe(input mode_e m);
        strobe_t s;
        s = '0;
        case (m)
            MODE_INIT:     s.init_load     = 1'b1;
            MODE_AD,
            MODE_AD_LAST,
            MODE_ENC,
            MODE_ENC_LAST: s.data_xor      = 1'b1;
            MODE_FINAL:    s.key_xor_final = 1'b1;
            default:       s = '0;
        endcase
        return s;
    endfunction

    function automatic strobe_t post_strobe(input mode_e m);
        strobe_t s;
        s = '0;
        case (m)
            MODE_INIT:    s.key_xor_init = 1'b1;
            MODE_AD_LAST: s.dsep_xor     = 1'b1;
            MODE_FINAL:   s.tag_xor      = 1'b1;
            default:      s = '0;
        endcase
        return s;
    endfunction

    function automatic logic has_post(input mode_e m);
        return |post_strobe(m);
    endfunction

endpackage

// File: rtl/ascon_round_ctrl_if.sv
// Command and strobe bundle between the SPI subnode (master) and the round sequencer (slave).
interface ascon_round_ctrl_if;
    logic [2:0] operation_mode;
    logic       operation_ready;
    logic       busy;
    logic       done;
    logic       cmd_err;
    logic       state_wr_block;
    logic       init_load;
    logic       data_xor;
    logic       key_xor_init;
    logic       dsep_xor;
    logic       key_xor_final;
    logic       tag_xor;
    logic       round_en;
    logic [3:0] round_idx;

    modport master (
        output operation_mode, operation_ready,
        input  busy, done, cmd_err, state_wr_block,
        input  init_load, data_xor, key_xor_init, dsep_xor, key_xor_final, tag_xor,
        input  round_en, round_idx
    );

    modport slave (
        input  operation_mode, operation_ready,
        output busy, done, cmd_err, state_wr_block,
        output init_load, data_xor, key_xor_init, dsep_xor, key_xor_final, tag_xor,
        output round_en, round_idx
    );
endinterface

// File: rtl/ascon_round_counter.sv
// Round down-counter and round-constant index generator for the Ascon sequencer.
// ASCON_ROUND_CTRL_UNROLL2_EN: two rounds per cycle, index steps by 2, round counts must be even.
module ascon_round_counter
    import ascon_pkg::*;
#(
    parameter int A_ROUNDS = 12,
    parameter int B_ROUNDS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  mode_e      mode,
    input  logic       load,
    input  logic       dec,
    output logic       zero,
    output logic       none,
    output logic [3:0] idx
);

`ifdef ASCON_ROUND_CTRL_UNROLL2_EN
    localparam logic [3:0] IDX_STEP = 4'd2;
    if ((A_ROUNDS % 2) != 0 || (B_ROUNDS % 2) != 0) begin : g_bad_unroll
        $error("A_ROUNDS and B_ROUNDS must be even when two rounds run per cycle");
    end
`else
    localparam logic [3:0] IDX_STEP = 4'd1;
`endif

    if (A_ROUNDS < 1 || A_ROUNDS > ASCON_MAX_ROUNDS ||
        B_ROUNDS < 1 || B_ROUNDS > ASCON_MAX_ROUNDS) begin : g_bad_rounds
        $error("A_ROUNDS and B_ROUNDS must lie in 1..12");
    end

    logic [3:0] rounds_s;
    logic [3:0] cycles_s;
    logic [3:0] start_idx_s;
    logic [3:0] cnt_r;
    logic [3:0] idx_r;

    // Round count per mode; the last rounds of the 12-round schedule are always used.
    always_comb begin
        rounds_s = 4'd0;
        case (mode)
            MODE_INIT,
            MODE_FINAL:   rounds_s = 4'(A_ROUNDS);
            MODE_AD,
            MODE_AD_LAST,
            MODE_ENC:     rounds_s = 4'(B_ROUNDS);
            default:      rounds_s = 4'd0;
        endcase
`ifdef ASCON_ROUND_CTRL_UNROLL2_EN
        cycles_s = {1'b0, rounds_s[3:1]};
`else
        cycles_s = rounds_s;
`endif
        start_idx_s = 4'(ASCON_MAX_ROUNDS) - rounds_s;
    end

    // Counter holds cycles remaining after the current one, so zero marks the last round cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
            idx_r <= 4'd0;
        end else if (load) begin
            cnt_r <= cycles_s - 4'd1;
            idx_r <= start_idx_s;
        end else if (dec) begin
            cnt_r <= cnt_r - 4'd1;
            idx_r <= idx_r + IDX_STEP;
        end else begin
            cnt_r <= cnt_r;
            idx_r <= 4'd0;
        end
    end

    assign zero = (cnt_r == 4'd0);
    assign none = (cycles_s == 4'd0);
    assign idx  = idx_r;

endmodule

// File: rtl/ascon_round_ctrl.sv
// Ascon permutation sequencer: per-operation PRE strobe, counted round burst, POST strobe, done.
// Honours ASCON_ROUND_CTRL_UNROLL2_EN through the round counter (two rounds per round_en cycle).
module ascon_round_ctrl
    import ascon_pkg::*;
#(
    parameter int A_ROUNDS = 12,
    parameter int B_ROUNDS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ascon_round_ctrl_if.slave    bus
);

    state_e     state_r;
    mode_e      mode_r;
    logic       ready_d_r;
    logic       busy_r;
    logic       done_r;
    logic       cmd_err_r;
    logic       round_en_r;
    strobe_t    strobe_r;

    logic       start_s;
    logic       cnt_load_s;
    logic       cnt_dec_s;
    logic       cnt_zero_s;
    logic       cnt_none_s;
    logic [3:0] cnt_idx_s;

    assign start_s    = bus.operation_ready & ~ready_d_r;
    assign cnt_load_s = (state_r == ST_PRE) & ~cnt_none_s;
    assign cnt_dec_s  = (state_r == ST_ROUNDS) & ~cnt_zero_s;

    ascon_round_counter #(
        .A_ROUNDS (A_ROUNDS),
        .B_ROUNDS (B_ROUNDS)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode_r),
        .load  (cnt_load_s),
        .dec   (cnt_dec_s),
        .zero  (cnt_zero_s),
        .none  (cnt_none_s),
        .idx   (cnt_idx_s)
    );

    // Sequencer FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_NONE;
            ready_d_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cmd_err_r  <= 1'b0;
            round_en_r <= 1'b0;
            strobe_r   <= '0;
        end else begin
            ready_d_r  <= bus.operation_ready;
            done_r     <= 1'b0;
            cmd_err_r  <= 1'b0;
            round_en_r <= 1'b0;
            strobe_r   <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s && mode_legal(bus.operation_mode)) begin
                        mode_r   <= mode_e'(bus.operation_mode);
                        state_r  <= ST_PRE;
                        busy_r   <= 1'b1;
                        strobe_r <= pre_strobe(mode_e'(bus.operation_mode));
                    end else begin
                        cmd_err_r <= start_s;
                    end
                end
                ST_PRE: begin
                    cmd_err_r <= start_s;
                    if (cnt_none_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r    <= ST_ROUNDS;
                        round_en_r <= 1'b1;
                    end
                end
                ST_ROUNDS: begin
                    cmd_err_r <= start_s;
                    if (!cnt_zero_s) begin
                        round_en_r <= 1'b1;
                    end else if (has_post(mode_r)) begin
                        state_r  <= ST_POST;
                        strobe_r <= post_strobe(mode_r);
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_POST: begin
                    cmd_err_r <= start_s;
                    state_r   <= ST_DONE;
                    done_r    <= 1'b1;
                end
                ST_DONE: begin
                    cmd_err_r <= start_s;
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = busy_r;
    assign bus.state_wr_block = busy_r;
    assign bus.done           = done_r;
    assign bus.cmd_err        = cmd_err_r;
    assign bus.init_load      = strobe_r.init_load;
    assign bus.data_xor       = strobe_r.data_xor;
    assign bus.key_xor_init   = strobe_r.key_xor_init;
    assign bus.dsep_xor       = strobe_r.dsep_xor;
    assign bus.key_xor_final  = strobe_r.key_xor_final;
    assign bus.tag_xor        = strobe_r.tag_xor;
    assign bus.round_en       = round_en_r;
    assign bus.round_idx      = cnt_idx_s;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Table-driven bench for ascon_round_ctrl: per-cycle output vectors against hand-derived operation traces.
module tb_ascon_round_ctrl;

`ifdef ASCON_ROUND_CTRL_UNROLL2_EN
    localparam int STEP = 2;
    localparam int N_A  = 6;
    localparam int N_B  = 3;
`else
    localparam int STEP = 1;
    localparam int N_A  = 12;
    localparam int N_B  = 6;
`endif

    typedef struct {
        logic [2:0] mode;
        logic [5:0] pre;
        int         nrnd;
        logic [3:0] idx0;
        logic [5:0] post;
        bit         err;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs [8];

    ascon_round_ctrl_if bus ();

    ascon_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] cur_outs();
        return {bus.busy, bus.done, bus.cmd_err, bus.state_wr_block,
                bus.init_load, bus.data_xor, bus.key_xor_init, bus.dsep_xor,
                bus.key_xor_final, bus.tag_xor, bus.round_en, bus.round_idx};
    endfunction

    // Expected outputs k cycles after the sampling edge of the request.
    function automatic logic [14:0] exp_at(input vec_t v, input int k, input bit extra_err);
        logic       busy;
        logic       done;
        logic       err;
        logic [5:0] s;
        logic       ren;
        logic [3:0] idx;
        int         len;
        busy = 1'b0; done = 1'b0; err = extra_err; s = 6'b0; ren = 1'b0; idx = 4'd0;
        len = 2 + v.nrnd + ((v.post != 6'b0) ? 1 : 0);
        if (v.err) begin
            if (k == 1) err = 1'b1;
        end else if (k >= 1 && k <= len) begin
            busy = 1'b1;
            if (k == 1) s = v.pre;
            else if (k <= v.nrnd + 1) begin
                ren = 1'b1;
                idx = v.idx0 + 4'((k - 2) * STEP);
            end else if (k == len) done = 1'b1;
            else s = v.post;
        end
        return {busy, done, err, busy, s, ren, idx};
    endfunction

    task automatic check(input string nm, input logic [14:0] exp);
        logic [14:0] act;
        act = cur_outs();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int retrig);
        int len;
        len = v.err ? 1 : 2 + v.nrnd + ((v.post != 6'b0) ? 1 : 0);
        @(posedge clk); #1;
        bus.operation_ready = 1'b0;
        @(posedge clk); #1;
        bus.operation_mode  = v.mode;
        bus.operation_ready = 1'b1;
        for (int k = 1; k <= len + 1; k++) begin
            @(posedge clk); #1;
            if (retrig > 0 && k == retrig)     bus.operation_ready = 1'b0;
            if (retrig > 0 && k == retrig + 1) bus.operation_ready = 1'b1;
            @(negedge clk);
            check($sformatf("%s c%0d", v.name, k), exp_at(v, k, retrig > 0 && k == retrig + 2));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //          mode    pre        nrnd idx0   post       err name
        vecs[0] = '{3'b001, 6'b100000, N_A, 4'd0,  6'b001000, 1'b0, "INIT"};
        vecs[1] = '{3'b010, 6'b010000, N_B, 4'd6,  6'b000000, 1'b0, "AD"};
        vecs[2] = '{3'b011, 6'b010000, N_B, 4'd6,  6'b000100, 1'b0, "AD_LAST"};
        vecs[3] = '{3'b100, 6'b010000, N_B, 4'd6,  6'b000000, 1'b0, "ENC"};
        vecs[4] = '{3'b101, 6'b010000, 0,   4'd0,  6'b000000, 1'b0, "ENC_LAST"};
        vecs[5] = '{3'b110, 6'b000010, N_A, 4'd0,  6'b000001, 1'b0, "FINAL"};
        vecs[6] = '{3'b000, 6'b000000, 0,   4'd0,  6'b000000, 1'b1, "ILL000"};
        vecs[7] = '{3'b111, 6'b000000, 0,   4'd0,  6'b000000, 1'b1, "ILL111"};

        rst_n = 1'b0;
        bus.operation_mode  = 3'b000;
        bus.operation_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 15'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i], 0);

        // Second request during FINAL rounds: cmd_err pulse, FINAL still completes.
        run_op(vecs[5], 3);

        // Synchronous reset during INIT rounds aborts with no done.
        @(posedge clk); #1;
        bus.operation_ready = 1'b0;
        @(posedge clk); #1;
        bus.operation_mode  = 3'b001;
        bus.operation_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_abort", exp_at(vecs[0], 5, 1'b0));
        rst_n = 1'b0;
        bus.operation_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_abort", 15'h0000);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("post_abort c%0d", k), 15'h0000);
        end

        run_op(vecs[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
